// File: rtl/fixed_dot_sequencer_pkg.sv
// fixed_dot_sequencer_pkg: shared FSM state type and default geometry for the Q16.16 dot-product sequencer
package fixed_dot_sequencer_pkg;
    localparam int LANES = 8;
    localparam int W     = 32;
    localparam int FRAC  = 16;
    localparam int ACC_W = 64;
    localparam int LEN_W = 8;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
endpackage

// File: rtl/fixed_dot8_stage.sv
// fixed_dot8_stage: two-cycle multiply-reduce of LANES signed lane pairs, valid travels with data
//   i_valid/i_a/i_b : chunk in (no backpressure)
//   o_pending       : a chunk sits in the first register stage
//   o_valid/o_sum   : partial sum, sign-extended to ACC_W, two cycles after i_valid
module fixed_dot8_stage #(
    parameter int LANES = fixed_dot_sequencer_pkg::LANES,
    parameter int W     = fixed_dot_sequencer_pkg::W,
    parameter int ACC_W = fixed_dot_sequencer_pkg::ACC_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    input  logic [LANES*W-1:0]      i_a,
    input  logic [LANES*W-1:0]      i_b,
    output logic                    o_pending,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_sum
);
    logic                    r_v1, r_v2;
    logic [LANES*W-1:0]      r_a, r_b;
    logic signed [ACC_W-1:0] r_sum, w_sum;
    logic signed [2*W-1:0]   w_prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= i_valid;
            r_v2 <= r_v1;
        end
    end

    // datapath registers carry no reset; the valid bits alone qualify them
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_a <= i_a;
            r_b <= i_b;
        end
        if (r_v1) r_sum <= w_sum;
    end

    always_comb begin
        w_sum  = '0;
        w_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            w_prod = (2*W)'($signed(r_a[i*W +: W])) * (2*W)'($signed(r_b[i*W +: W]));
            w_sum  = w_sum + ACC_W'(w_prod);
        end
    end

    assign o_pending = r_v1;
    assign o_valid   = r_v2;
    assign o_sum     = r_sum;
endmodule

// File: rtl/fixed_dot_sequencer.sv
// fixed_dot_sequencer: accepts a chunk-count job, accumulates LANES-wide Q16.16 dot products, returns the result
//   cmd_valid/cmd_ready/cmd_len : job request, cmd_len chunks (0 legal)
//   in_valid/in_ready/in_a/in_b : operand chunks, lane i at [i*W +: W]
//   out_valid/out_ready/out_c/out_ovf : Q16.16 result and out-of-range flag
module fixed_dot_sequencer #(
    parameter int LANES = fixed_dot_sequencer_pkg::LANES,
    parameter int W     = fixed_dot_sequencer_pkg::W,
    parameter int FRAC  = fixed_dot_sequencer_pkg::FRAC,
    parameter int ACC_W = fixed_dot_sequencer_pkg::ACC_W,
    parameter int LEN_W = fixed_dot_sequencer_pkg::LEN_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_c,
    output logic               out_ovf
);
    import fixed_dot_sequencer_pkg::*;

    state_t                  r_state, w_next;
    logic [LEN_W-1:0]        r_len, r_cnt;
    logic signed [ACC_W-1:0] r_acc, w_sum, w_sh;
    logic                    w_cmd_hs, w_in_hs, w_last, w_pending, w_sum_valid;

    assign w_cmd_hs = cmd_valid && cmd_ready;
    assign w_in_hs  = in_valid && in_ready;
    assign w_last   = w_in_hs && (r_cnt + LEN_W'(1) == r_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // DRAIN leaves on the edge that accumulates the last partial sum,
    // so out_valid lands three cycles after the final chunk handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cmd_hs) w_next = (cmd_len == '0) ? DONE : LOAD;
            LOAD:    if (w_last) w_next = DRAIN;
            DRAIN:   if (!w_pending) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        in_ready  = (r_state == LOAD);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len <= '0;
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_cmd_hs) begin
            r_len <= cmd_len;
            r_cnt <= '0;
            r_acc <= '0;
        end else begin
            if (w_in_hs)     r_cnt <= r_cnt + LEN_W'(1);
            if (w_sum_valid) r_acc <= r_acc + w_sum;
        end
    end

    fixed_dot8_stage #(.LANES(LANES), .W(W), .ACC_W(ACC_W)) u_stage (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (w_in_hs),
        .i_a       (in_a),
        .i_b       (in_b),
        .o_pending (w_pending),
        .o_valid   (w_sum_valid),
        .o_sum     (w_sum)
    );

    // accumulator is frozen in DONE, so the decoded result stays stable
    assign w_sh    = r_acc >>> FRAC;
    assign out_c   = w_sh[W-1:0];
    assign out_ovf = !(&w_sh[ACC_W-1:W-1]) && (|w_sh[ACC_W-1:W-1]);
endmodule

// File: tb/tb_fixed_dot_sequencer.sv
// tb_fixed_dot_sequencer: vector table, hand sequences and randomized jobs against an arithmetic model
module tb_fixed_dot_sequencer;
    localparam int LANES = 8;
    localparam int W     = 32;
    localparam int LEN_W = 8;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [LEN_W-1:0]   cmd_len = '0;
    logic [LANES*W-1:0] in_a = '0;
    logic [LANES*W-1:0] in_b = '0;
    logic               cmd_ready, in_ready, out_valid, out_ovf;
    logic [W-1:0]       out_c;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ja [8][8];
    logic [31:0] jb [8][8];

    typedef struct {
        int          len;
        int          bub;
        int          hold;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        ovf;
    } vec_t;
    vec_t vecs [10];

    fixed_dot_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // result of a job purely from the arithmetic definition
    task automatic model(input int len, output logic [31:0] c, output logic ovf);
        longint acc, sh;
        acc = 0;
        for (int j = 0; j < len; j++)
            for (int i = 0; i < LANES; i++)
                acc += longint'($signed(ja[j][i])) * longint'($signed(jb[j][i]));
        sh  = acc >>> 16;
        c   = sh[31:0];
        ovf = (sh < -64'sd2147483648) || (sh > 64'sd2147483647);
    endtask

    task automatic do_job(input string tag, input int len, input int bub, input int hold,
                          output logic [31:0] c, output logic ovf);
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin tick(); k++; end
        check({tag, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
        for (int j = 0; j < len; j++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, bub)) tick();
            in_valid = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                in_a[i*W +: W] = ja[j][i];
                in_b[i*W +: W] = jb[j][i];
            end
            k = 0;
            while (!in_ready && k < 50) begin tick(); k++; end
            check({tag, " in_ready"}, in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_a[i*W +: W] = $urandom;
            in_b[i*W +: W] = $urandom;
        end
        check({tag, " in_ready_after"}, in_ready, 0);
        k = 1;
        while (!out_valid && k < 20) begin tick(); k++; end
        check({tag, " latency"}, 64'(k), (len == 0) ? 64'd1 : 64'd3);
        c   = out_c;
        ovf = out_ovf;
        cmd_valid = (hold > 0);
        cmd_len   = 8'd1;
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, " hold"}, {out_valid, cmd_ready, in_ready, out_c}, {1'b1, 1'b0, 1'b0, c});
        end
        cmd_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " post"}, {out_valid, cmd_ready}, 2'b01);
    endtask

    task automatic fill(input int len, input logic [31:0] a, input logic [31:0] b);
        for (int j = 0; j < len; j++)
            for (int i = 0; i < LANES; i++) begin
                ja[j][i] = a;
                jb[j][i] = b;
            end
    endtask

    initial begin
        logic [31:0] c, mc;
        logic        ovf, movf, seen;
        int          len;

        vecs[0] = '{1, 0, 5, 32'h00010000, 32'h00010000, 32'h00080000, 1'b0};
        vecs[1] = '{1, 0, 0, 32'hFFFF0000, 32'h00008000, 32'hFFFC0000, 1'b0};
        vecs[2] = '{3, 3, 0, 32'h00010000, 32'h00010000, 32'h00180000, 1'b0};
        vecs[3] = '{0, 0, 2, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0};
        vecs[4] = '{1, 0, 0, 32'h7FFF0000, 32'h7FFF0000, 32'h00080000, 1'b1};
        vecs[5] = '{2, 1, 0, 32'h00020000, 32'h00030000, 32'h00600000, 1'b0};
        vecs[6] = '{1, 0, 0, 32'h00400000, 32'h00400000, 32'h80000000, 1'b1};
        vecs[7] = '{1, 0, 0, 32'hFFC00000, 32'h00400000, 32'h80000000, 1'b0};
        vecs[8] = '{1, 0, 0, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9] = '{1, 0, 0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0};

        repeat (2) tick();
        check("reset outputs", {cmd_ready, in_ready, out_valid, out_ovf, out_c}, {4'b1000, 32'h0});
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 10; v++) begin
            fill(vecs[v].len, vecs[v].a, vecs[v].b);
            do_job($sformatf("vec%0d", v), vecs[v].len, vecs[v].bub, vecs[v].hold, c, ovf);
            check($sformatf("vec%0d out_c", v), c, vecs[v].c);
            check($sformatf("vec%0d out_ovf", v), ovf, vecs[v].ovf);
        end

        // reset in the middle of a two-chunk job
        fill(2, 32'h00010000, 32'h00010000);
        cmd_valid = 1'b1;
        cmd_len   = 8'd2;
        tick();
        cmd_valid = 1'b0;
        in_valid  = 1'b1;
        in_a      = {LANES{32'h00010000}};
        in_b      = {LANES{32'h00010000}};
        tick();
        in_valid = 1'b0;
        check("midreset in LOAD", in_ready, 1);
        reset_n = 1'b0;
        #1;
        check("midreset async", {cmd_ready, in_ready, out_valid, out_c}, {3'b100, 32'h0});
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen |= out_valid;
        end
        check("midreset no out_valid", seen, 0);
        fill(1, 32'h00010000, 32'h00010000);
        do_job("after_reset", 1, 0, 0, c, ovf);
        check("after_reset out_c", c, 32'h00080000);

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 4);
            for (int j = 0; j < len; j++)
                for (int i = 0; i < LANES; i++) begin
                    ja[j][i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h3FFFFF) - 32'h200000;
                    jb[j][i] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h3FFFFF) - 32'h200000;
                end
            model(len, mc, movf);
            do_job($sformatf("rnd%0d", r), len, 2, $urandom_range(0, 3), c, ovf);
            check($sformatf("rnd%0d out_c", r), c, mc);
            check($sformatf("rnd%0d out_ovf", r), ovf, movf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_dot_sequencer.md
FIXED_DOT_SEQUENCER -- requirements
Module: fixed_dot_sequencer

Interface
REQ-001 SHALL have parameters: LANES, default 8, vector elements per chunk; W, default 32, element width; FRAC, default 16, fraction bits (Q16.16); ACC_W, default 64, accumulator width; LEN_W, default 8, chunk-count width.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line below:
clk  in  1  single clock; all state changes on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  job request.
cmd_ready  out  1  sequencer can accept a job.
cmd_len  in  LEN_W  number of chunks in the job; 0 is legal.
in_valid  in  1  chunk present.
in_ready  out  1  chunk accepted this cycle when in_valid is also high.
in_a  in  LANES*W  signed operand lanes; lane i at bits [i*W +: W].
in_b  in  LANES*W  signed operand lanes, same packing as in_a.
out_valid  out  1  result available.
out_ready  in  1  consumer takes the result.
out_c  out  W  signed Q16.16 dot product.
out_ovf  out  1  result did not fit in W signed bits.

Function
REQ-003 SHALL use FSM states IDLE, LOAD, DRAIN and DONE.
REQ-004 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len, clear the accumulator, and go to LOAD, or to DONE if cmd_len=0.
REQ-005 LOAD: in_ready=1; each in_valid&&in_ready handshake issues one chunk to the multiply-reduce stage; back-to-back handshakes SHALL be supported, one chunk per cycle.
REQ-006 LOAD SHALL go to DRAIN in the cycle after the cmd_len-th chunk handshake; in_ready SHALL be 0 in every state except LOAD.
REQ-007 Multiply-reduce stage: cycle t+1 registers the lanes; cycle t+2 registers the sum of the LANES full-width signed products, sign-extended to ACC_W; a valid bit SHALL travel with each chunk through the stage.
REQ-008 The accumulator SHALL add each valid partial sum, in ACC_W bits with two's-complement wrap; no saturation of the accumulator.
REQ-009 DRAIN SHALL go to DONE once the stage's valid bits are clear and the last partial sum has been accumulated.
REQ-010 out_valid SHALL assert exactly 3 cycles after the final chunk handshake.
REQ-011 For cmd_len=0, out_valid SHALL assert in the cycle after the command handshake, with out_c=0 and out_ovf=0.
REQ-012 out_c SHALL equal bits [W-1:0] of (accumulator >>> FRAC), using an arithmetic shift; this is truncation, not saturation.
REQ-013 out_ovf SHALL be 1 iff (accumulator >>> FRAC) lies outside [-2^(W-1), 2^(W-1)-1].
REQ-014 DONE: out_valid=1, with out_c and out_ovf held stable until out_valid&&out_ready; on that handshake, go to IDLE.
REQ-015 cmd_valid SHALL be ignored outside IDLE.
REQ-016 in_valid SHALL be ignored outside LOAD, and in_a/in_b SHALL be don't-care when no handshake occurs.
REQ-017 No new job SHALL be accepted in the same cycle as the result handshake; the next cmd handshake is possible one cycle later.

Reset
REQ-018 While reset_n=0, asynchronously: FSM=IDLE, accumulator=0, stage valid bits=0, chunk counter=0, out_valid=0, out_c=0, out_ovf=0, in_ready=0.
REQ-019 cmd_ready SHALL be 1 while in reset, as decoded from IDLE.
REQ-020 Reset asserted mid-job SHALL discard all in-flight chunks; no out_valid pulse SHALL follow reset release.
REQ-021 Lane data registers need not be reset.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, LANES, W, FRAC and ACC_W.
REQ-023 The multiply-reduce stage SHALL be the sub-module fixed_dot8_stage: 2-cycle latency, valid-in/valid-out, no backpressure.
REQ-024 The FSM, counter, accumulator and output logic SHALL reside in fixed_dot_sequencer.

Verification
REQ-025 cmd_len=1, all lanes a=b=0x00010000 (1.0) -> out_c=0x00080000, out_ovf=0, out_valid exactly 3 cycles after the handshake.
REQ-026 cmd_len=1, a=0xFFFF0000 (-1.0), b=0x00008000 (0.5) on all lanes -> out_c=0xFFFC0000 (-4.0), out_ovf=0.
REQ-027 cmd_len=3 with in_valid bubbles between chunks, each chunk a=b=1.0 -> out_c=0x00180000; in_ready=0 after the third handshake.
REQ-028 cmd_len=0 -> out_valid in the cycle after the command handshake, with out_c=0.
REQ-029 cmd_len=1, a=b=0x7FFF0000 on all lanes -> out_ovf=1.
REQ-030 Backpressure: hold out_ready=0 for 5 cycles -> out_c stable, cmd_ready=0, and a cmd_valid presented meanwhile is not taken.
REQ-031 Reset mid-job: pulse reset_n low in LOAD after 1 of 2 chunks -> IDLE, out_valid=0; a following 1-chunk job yields only its own result.
